alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60: number of seconds the alarm rings before it auto-stops; legal range 1..1023.
REQ-002 Parameter SNOOZE_SEC, default 540: length of the snooze interval in seconds; legal range 1..1023.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum number of snoozes accepted per alarm event; legal range 0..7.
REQ-004 clk  in  1  block clock, 1 cycle per second (the Pulse domain); one clock only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 alarmon  in  1  level; alarm enabled.
REQ-007 snooze  in  1  level from a button; only its rising edge acts.
REQ-008 tsec  in  7  current time, seconds (0..59).
REQ-009 tmin, thrs  in  7 each  current time, minutes (0..59) and hours (0..23).
REQ-010 amin, ahrs  in  7 each  alarm setting, minutes and hours.
REQ-011 buzz  out  1  registered; alarm sounding.
REQ-012 state  out  2  registered FSM state: OFF=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-013 snz_cnt  out  3  registered; snoozes taken in the current alarm event.
REQ-014 time_left  out  10  registered; seconds remaining in the current RINGING or SNOOZE interval; 0 in OFF and ARMED.

Function
REQ-015 The block SHALL compute match = (tsec==0) && (tmin==amin) && (thrs==ahrs), combinationally and internally.
REQ-016 The block SHALL register snooze each cycle (snz_q, reset 0) and SHALL define snz_edge = snooze && !snz_q.
REQ-017 alarmon==0 in any state SHALL force state OFF on the next cycle, with time_left=0 and snz_cnt=0; this has priority over every other transition.
REQ-018 OFF: alarmon==1 SHALL move the FSM to ARMED next cycle.
REQ-019 ARMED: match==1 SHALL move the FSM to RINGING next cycle, with time_left=RING_SEC-1 and snz_cnt=0.
REQ-020 RINGING, when snz_edge==1 and snz_cnt<MAX_SNOOZE: next cycle the FSM SHALL be in SNOOZE, with time_left=SNOOZE_SEC-1 and snz_cnt incremented by 1.
REQ-021 RINGING, when snz_edge==1 and snz_cnt==MAX_SNOOZE: the snooze edge SHALL be ignored and ringing SHALL continue.
REQ-022 RINGING, otherwise, when time_left==0: the FSM SHALL go to ARMED, with snz_cnt=0.
REQ-023 RINGING, otherwise: time_left SHALL decrement by 1.
REQ-024 A valid snooze edge arriving on the same cycle as time_left==0 SHALL win; the FSM goes to SNOOZE.
REQ-025 SNOOZE, when time_left==0: the FSM SHALL go to RINGING, with time_left=RING_SEC-1 and snz_cnt held.
REQ-026 SNOOZE, otherwise: time_left SHALL decrement by 1.
REQ-027 match and snz_edge SHALL be ignored in SNOOZE.
REQ-028 match SHALL be ignored in RINGING; there is no restart of the ring interval.
REQ-029 buzz SHALL equal 1 exactly when the registered state is RINGING. Latency: match true in cycle n gives buzz=1 in cycle n+1.
REQ-030 time_left arithmetic SHALL be 10-bit unsigned and SHALL never underflow, because reload happens at 0.
REQ-031 snz_cnt SHALL saturate at MAX_SNOOZE.
REQ-032 A match seen in ARMED on the cycle alarmon falls SHALL yield OFF, not RINGING.
REQ-033 Alarm or time changes (amin, ahrs, tmin, thrs) during RINGING or SNOOZE SHALL NOT affect the current event.

Reset
REQ-034 While rst==1 at a clk edge, the block SHALL load: state=OFF, buzz=0, snz_cnt=0, time_left=0, snz_q=0.
REQ-035 rst SHALL override all inputs, including mid-RINGING and mid-SNOOZE.
REQ-036 After rst deasserts with alarmon==1, the FSM SHALL enter ARMED one cycle later.

Verification
REQ-037 Basic ring: alarmon=1, ahrs=7, amin=30; time steps to 07:30:00. Required: buzz=1 from the next cycle for exactly 60 cycles (RING_SEC=60), then state=ARMED, buzz=0.
REQ-038 Snooze: while RINGING at time_left=50, raise snooze. Required: next cycle state=SNOOZE, snz_cnt=1, time_left=539, buzz=0. After 540 cycles, state=RINGING with time_left=59.
REQ-039 Snooze limit: press snooze 4 times, each during RINGING (MAX_SNOOZE=3). Required: snz_cnt reaches 3 and the 4th press is ignored. Ringing ends after 60 cycles, then ARMED with snz_cnt=0.
REQ-040 Held button: keep snooze=1 continuously from before RINGING begins. Required: no snooze is taken (no edge); a release followed by a press then snoozes.
REQ-041 Priority: drop alarmon during SNOOZE → OFF next cycle with all counters 0. Separately, a snooze edge in the same cycle as ring time_left=0 → SNOOZE, not ARMED.
REQ-042 Reset: assert rst mid-RINGING → next cycle OFF, buzz=0, time_left=0, snz_cnt=0. Deassert rst with alarmon=1 → ARMED one cycle later.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arms on alarmon, rings on an hh:mm:00 match, and supports a bounded number of snoozes.
// All outputs are registered; the timebase is one clk per second.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 540,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarmon,
  input  logic       snooze,
  input  logic [6:0] tsec,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  output logic       buzz,
  output logic [1:0] state,
  output logic [2:0] snz_cnt,
  output logic [9:0] time_left
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_e;

  localparam logic [9:0] RING_RELOAD   = 10'(RING_SEC - 1);
  localparam logic [9:0] SNOOZE_RELOAD = 10'(SNOOZE_SEC - 1);
  localparam logic [2:0] SNZ_MAX       = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic       buzz_q, buzz_d;
  logic [2:0] snz_cnt_q, snz_cnt_d;
  logic [9:0] time_left_q, time_left_d;
  logic       snz_q;
  logic       match;
  logic       snz_edge;

  assign match    = (tsec == 7'd0) && (tmin == amin) && (thrs == ahrs);
  assign snz_edge = snooze && !snz_q;

  always_comb begin
    state_d     = state_q;
    snz_cnt_d   = snz_cnt_q;
    time_left_d = time_left_q;
    if (!alarmon) begin
      state_d     = ST_OFF;
      snz_cnt_d   = 3'd0;
      time_left_d = 10'd0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_d     = ST_RINGING;
            time_left_d = RING_RELOAD;
            snz_cnt_d   = 3'd0;
          end
        end
        ST_RINGING: begin
          // A usable snooze press beats ring expiry in the same cycle.
          if (snz_edge && (snz_cnt_q < SNZ_MAX)) begin
            state_d     = ST_SNOOZE;
            time_left_d = SNOOZE_RELOAD;
            snz_cnt_d   = snz_cnt_q + 3'd1;
          end else if (time_left_q == 10'd0) begin
            state_d   = ST_ARMED;
            snz_cnt_d = 3'd0;
          end else begin
            time_left_d = time_left_q - 10'd1;
          end
        end
        ST_SNOOZE: begin
          if (time_left_q == 10'd0) begin
            state_d     = ST_RINGING;
            time_left_d = RING_RELOAD;
          end else begin
            time_left_d = time_left_q - 10'd1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    buzz_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      buzz_q      <= 1'b0;
      snz_cnt_q   <= 3'd0;
      time_left_q <= 10'd0;
      snz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buzz_q      <= buzz_d;
      snz_cnt_q   <= snz_cnt_d;
      time_left_q <= time_left_d;
      snz_q       <= snooze;
    end
  end

  assign buzz      = buzz_q;
  assign state     = state_q;
  assign snz_cnt   = snz_cnt_q;
  assign time_left = time_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed testbench for alarm_ctrl with default parameters (ring 60 s, snooze 540 s, 3 snoozes).
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarmon;
  logic       snooze;
  logic [6:0] tsec, tmin, thrs, amin, ahrs;
  logic       buzz;
  logic [1:0] state;
  logic [2:0] snz_cnt;
  logic [9:0] time_left;

  int vec  = 0;
  int errs = 0;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .alarmon(alarmon), .snooze(snooze),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .amin(amin), .ahrs(ahrs),
    .buzz(buzz), .state(state), .snz_cnt(snz_cnt), .time_left(time_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present 07:30:00 for one cycle, then move the seconds on.
  task automatic fire_alarm();
    thrs = 7'd7; tmin = 7'd30; tsec = 7'd0;
    tick();
    tsec = 7'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alarmon = 1'b0; snooze = 1'b0;
    tsec = 7'd0; tmin = 7'd0; thrs = 7'd0; amin = 7'd30; ahrs = 7'd7;
    tick(); tick();
    vec++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", state); end
    vec++; if (buzz !== 1'b0) begin errs++; $display("FAIL reset_buzz: got %0b want 0", buzz); end
    vec++; if (snz_cnt !== 3'd0) begin errs++; $display("FAIL reset_snz_cnt: got %0d want 0", snz_cnt); end
    vec++; if (time_left !== 10'd0) begin errs++; $display("FAIL reset_time_left: got %0d want 0", time_left); end
    rst = 1'b0; alarmon = 1'b1;
    tick();
    vec++; if (state !== 2'd1) begin errs++; $display("FAIL reset_to_armed: got %0d want 1", state); end
  endtask

  task automatic test_basic_ring();
    int n;
    int cnt;
    thrs = 7'd7; tmin = 7'd29; tsec = 7'd59;
    tick();
    vec++; if (state !== 2'd1) begin errs++; $display("FAIL ring_premature: got %0d want 1", state); end
    fire_alarm();
    vec++; if (buzz !== 1'b1) begin errs++; $display("FAIL ring_buzz_latency: got %0b want 1", buzz); end
    vec++; if (time_left !== 10'd59) begin errs++; $display("FAIL ring_time_left_load: got %0d want 59", time_left); end
    cnt = 1; n = 0;
    while (buzz === 1'b1 && n < 100) begin
      tick(); n++;
      if (buzz === 1'b1) cnt++;
    end
    vec++; if (cnt != 60) begin errs++; $display("FAIL ring_duration: got %0d want 60", cnt); end
    vec++; if (state !== 2'd1) begin errs++; $display("FAIL ring_end_state: got %0d want 1", state); end
    vec++; if (snz_cnt !== 3'd0) begin errs++; $display("FAIL ring_end_snz_cnt: got %0d want 0", snz_cnt); end
  endtask

  task automatic test_snooze();
    fire_alarm();
    repeat (9) tick();
    vec++; if (time_left !== 10'd50) begin errs++; $display("FAIL snz_pre_time_left: got %0d want 50", time_left); end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    vec++; if (state !== 2'd3) begin errs++; $display("FAIL snz_state: got %0d want 3", state); end
    vec++; if (snz_cnt !== 3'd1) begin errs++; $display("FAIL snz_cnt: got %0d want 1", snz_cnt); end
    vec++; if (time_left !== 10'd539) begin errs++; $display("FAIL snz_time_left: got %0d want 539", time_left); end
    vec++; if (buzz !== 1'b0) begin errs++; $display("FAIL snz_buzz: got %0b want 0", buzz); end
    repeat (539) tick();
    vec++; if (state !== 2'd3 || time_left !== 10'd0) begin errs++; $display("FAIL snz_last_cycle: got state %0d tl %0d want 3/0", state, time_left); end
    tick();
    vec++; if (state !== 2'd2 || time_left !== 10'd59) begin errs++; $display("FAIL snz_rering: got state %0d tl %0d want 2/59", state, time_left); end
    vec++; if (snz_cnt !== 3'd1) begin errs++; $display("FAIL snz_cnt_held: got %0d want 1", snz_cnt); end
    alarmon = 1'b0;
    tick();
    vec++; if (state !== 2'd0 || buzz !== 1'b0) begin errs++; $display("FAIL snz_off: got state %0d buzz %0b want 0/0", state, buzz); end
    alarmon = 1'b1;
    tick();
  endtask

  task automatic test_snooze_limit();
    int n;
    fire_alarm();
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      vec++; if (state !== 2'd3 || snz_cnt !== 3'(k)) begin errs++; $display("FAIL limit_press%0d: got state %0d cnt %0d want 3/%0d", k, state, snz_cnt, k); end
      n = 0;
      while (state !== 2'd2 && n < 1000) begin tick(); n++; end
      vec++; if (n != 540) begin errs++; $display("FAIL limit_snooze_len%0d: got %0d want 540", k, n); end
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    vec++; if (state !== 2'd2 || snz_cnt !== 3'd3 || time_left !== 10'd58) begin
      errs++; $display("FAIL limit_fourth_press: got state %0d cnt %0d tl %0d want 2/3/58", state, snz_cnt, time_left);
    end
    n = 0;
    while (state === 2'd2 && n < 100) begin tick(); n++; end
    vec++; if (n != 59) begin errs++; $display("FAIL limit_ring_tail: got %0d want 59", n); end
    vec++; if (state !== 2'd1 || snz_cnt !== 3'd0) begin errs++; $display("FAIL limit_end: got state %0d cnt %0d want 1/0", state, snz_cnt); end
  endtask

  task automatic test_held_button();
    snooze = 1'b1;
    tick();
    fire_alarm();
    tick();
    vec++; if (state !== 2'd2 || snz_cnt !== 3'd0 || time_left !== 10'd58) begin
      errs++; $display("FAIL held_no_snooze: got state %0d cnt %0d tl %0d want 2/0/58", state, snz_cnt, time_left);
    end
    snooze = 1'b0;
    tick();
    snooze = 1'b1;
    tick();
    vec++; if (state !== 2'd3 || snz_cnt !== 3'd1 || time_left !== 10'd539) begin
      errs++; $display("FAIL held_repress: got state %0d cnt %0d tl %0d want 3/1/539", state, snz_cnt, time_left);
    end
    snooze = 1'b0;
    repeat (5) tick();
    alarmon = 1'b0;
    tick();
    vec++; if (state !== 2'd0 || snz_cnt !== 3'd0 || time_left !== 10'd0 || buzz !== 1'b0) begin
      errs++; $display("FAIL prio_off_in_snooze: got state %0d cnt %0d tl %0d buzz %0b want 0/0/0/0", state, snz_cnt, time_left, buzz);
    end
    alarmon = 1'b1;
    tick();
  endtask

  task automatic test_tie_and_match();
    fire_alarm();
    tsec = 7'd0;
    tick();
    tsec = 7'd1;
    vec++; if (time_left !== 10'd58) begin errs++; $display("FAIL match_in_ringing: got tl %0d want 58", time_left); end
    amin = 7'd45; ahrs = 7'd9;
    repeat (58) tick();
    vec++; if (state !== 2'd2 || time_left !== 10'd0) begin errs++; $display("FAIL tie_setup: got state %0d tl %0d want 2/0", state, time_left); end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    vec++; if (state !== 2'd3 || snz_cnt !== 3'd1) begin errs++; $display("FAIL tie_snooze_wins: got state %0d cnt %0d want 3/1", state, snz_cnt); end
    amin = 7'd30; ahrs = 7'd7;
    alarmon = 1'b0;
    tick();
    alarmon = 1'b1;
    tick();
    thrs = 7'd7; tmin = 7'd30; tsec = 7'd0; alarmon = 1'b0;
    tick();
    tsec = 7'd1;
    vec++; if (state !== 2'd0 || buzz !== 1'b0) begin errs++; $display("FAIL match_with_alarmoff: got state %0d buzz %0b want 0/0", state, buzz); end
    alarmon = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_ring();
    fire_alarm();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    vec++; if (state !== 2'd0 || buzz !== 1'b0 || time_left !== 10'd0 || snz_cnt !== 3'd0) begin
      errs++; $display("FAIL rst_mid_ring: got state %0d buzz %0b tl %0d cnt %0d want 0/0/0/0", state, buzz, time_left, snz_cnt);
    end
    rst = 1'b0;
    tick();
    vec++; if (state !== 2'd1) begin errs++; $display("FAIL rst_release_armed: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_snooze();
    test_snooze_limit();
    test_held_button();
    test_tie_and_match();
    test_reset_mid_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
